// File: rtl/register_bank_onehot.sv
// -----------------------------------------------------------------------------
// register_bank_onehot
//
// Sixteen 32-bit general-purpose registers addressed by one-hot select
// vectors coming from the 4-to-16 register-select decoders of the datapath.
//
// Ports
//   clk      in   1   rising-edge clock, single domain
//   clr      in   1   asynchronous active-high reset (registers, flag, counter)
//   Rin      in  16   one-hot write enable, bit k writes R[k]
//   Rout     in  16   one-hot read select, bit j reads R[j]
//   BAout    in   1   base-address qualifier, forces R0 to read as zero
//   d_in     in  32   write data
//   q_out    out 32   combinational read data (zero unless Rout is one-hot)
//   rd_act   out  1   Rout has exactly one bit set
//   sel_err  out  1   sticky flag, set by any multi-hot Rin or Rout
//   wr_cnt   out 16   saturating count of committed writes
// -----------------------------------------------------------------------------
module register_bank_onehot (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] Rin,
  input  logic [15:0] Rout,
  input  logic        BAout,
  input  logic [31:0] d_in,
  output logic [31:0] q_out,
  output logic        rd_act,
  output logic        sel_err,
  output logic [15:0] wr_cnt
);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'h0) && ((v & (v - 16'h1)) == 16'h0);
  endfunction

  function automatic logic is_multihot(input logic [15:0] v);
    return (v != 16'h0) && !is_onehot(v);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'h1;
  endfunction

  logic [15:0][31:0] regs_q, regs_d;
  logic              sel_err_q, sel_err_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              wr_ok;
  logic              rd_ok;
  logic [31:0]       rd_data;

  assign wr_ok = is_onehot(Rin);
  assign rd_ok = is_onehot(Rout);

  // Write side: only a one-hot Rin commits; zero or multi-hot leaves all held.
  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_ok) begin
      for (int k = 0; k < 16; k++) begin
        if (Rin[4'(k)]) regs_d[4'(k)] = d_in;
      end
      wr_cnt_d = sat_inc(wr_cnt_q);
    end
    sel_err_d = sel_err_q | is_multihot(Rin) | is_multihot(Rout);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      regs_q    <= '0;
      sel_err_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      regs_q    <= regs_d;
      sel_err_q <= sel_err_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Read side: AND-OR mux over the one-hot select. R0 is masked while BAout
  // is high so base-address arithmetic sees a zero base. The whole result is
  // gated by rd_ok so a multi-hot select reads as zero rather than an OR.
  always_comb begin
    rd_data = 32'h0;
    for (int j = 0; j < 16; j++) begin
      if (Rout[4'(j)] && !((j == 0) && BAout)) rd_data = rd_data | regs_q[4'(j)];
    end
  end

  assign q_out   = rd_ok ? rd_data : 32'h0;
  assign rd_act  = rd_ok;
  assign sel_err = sel_err_q;
  assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_register_bank_onehot.sv
module tb_register_bank_onehot;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        BAout;
  logic [31:0] d_in;
  logic [31:0] q_out;
  logic        rd_act;
  logic        sel_err;
  logic [15:0] wr_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: register contents, sticky error, commit count.
  logic [31:0] mdl [16];
  logic        mdl_err;
  logic [15:0] mdl_cnt;

  always #50 clk = ~clk;

  register_bank_onehot dut (
    .clk    (clk),
    .clr    (clr),
    .Rin    (Rin),
    .Rout   (Rout),
    .BAout  (BAout),
    .d_in   (d_in),
    .q_out  (q_out),
    .rd_act (rd_act),
    .sel_err(sel_err),
    .wr_cnt (wr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    mdl_err = 1'b0;
    mdl_cnt = 16'h0;
  endtask

  function automatic logic [31:0] mdl_read(input logic [15:0] rout, input logic ba);
    int j;
    if ($countones(rout) != 1) return 32'h0;
    j = $clog2(rout);
    if (j == 0 && ba) return 32'h0;
    return mdl[j];
  endfunction

  // Effect of one rising edge with the current inputs and clr low.
  task automatic mdl_edge();
    if ($countones(Rin) == 1) begin
      mdl[$clog2(Rin)] = d_in;
      if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'h1;
    end
    if ($countones(Rin) > 1 || $countones(Rout) > 1) mdl_err = 1'b1;
  endtask

  // One clock cycle: check the combinational read before the edge, then the
  // read and the state after it.
  task automatic step(input logic [15:0] rin, input logic [15:0] rout,
                      input logic ba, input logic [31:0] d);
    Rin = rin; Rout = rout; BAout = ba; d_in = d;
    #1;
    chk("q_pre", q_out, mdl_read(rout, ba));
    chk("rd_act", {31'h0, rd_act}, {31'h0, ($countones(rout) == 1)});
    @(posedge clk);
    mdl_edge();
    #1;
    chk("q_post", q_out, mdl_read(rout, ba));
    chk("sel_err", {31'h0, sel_err}, {31'h0, mdl_err});
    chk("wr_cnt", {16'h0, wr_cnt}, {16'h0, mdl_cnt});
  endtask

  function automatic logic [15:0] gen_sel(input int pmulti);
    int r, a, b;
    r = int'($urandom_range(0, 99));
    a = int'($urandom_range(0, 15));
    if (r < pmulti) begin
      b = (a + 1 + int'($urandom_range(0, 14))) % 16;
      return 16'(1 << a) | 16'(1 << b);
    end else if (r < pmulti + 15) begin
      return 16'h0;
    end
    return 16'(1 << a);
  endfunction

  // Asynchronous clr between edges, then a write whose edge sees clr high.
  task automatic pulse_clr();
    #20;
    clr = 1'b1;
    #1;
    mdl_clear();
    for (int j = 0; j < 16; j++) begin
      Rout = 16'(1 << j); BAout = 1'b0;
      #1;
      chk("clr_reg", q_out, 32'h0);
    end
    chk("clr_sel_err", {31'h0, sel_err}, 32'h0);
    chk("clr_wr_cnt", {16'h0, wr_cnt}, 32'h0);
    Rin = 16'h0004; d_in = 32'hCAFEF00D; Rout = 16'h0004;
    @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    chk("clr_discard_q", q_out, 32'h0);
    chk("clr_discard_cnt", {16'h0, wr_cnt}, 32'h0);
    Rin = 16'h0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; Rin = 16'h0020; Rout = 16'h0020; BAout = 1'b0; d_in = 32'hFFFFFFFF;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q_out, 32'h0);
    chk("rst_sel_err", {31'h0, sel_err}, 32'h0);
    chk("rst_wr_cnt", {16'h0, wr_cnt}, 32'h0);
    Rin = 16'h0;
    #10;
    clr = 1'b0;

    // First edge after reset writes R5; then read it back.
    step(16'h0020, 16'h0000, 1'b0, 32'hDEADBEEF);
    step(16'h0000, 16'h0020, 1'b0, 32'h0);
    chk("r5_q", q_out, 32'hDEADBEEF);
    chk("r5_rd_act", {31'h0, rd_act}, 32'h1);
    chk("r5_cnt", {16'h0, wr_cnt}, 32'h1);

    // R0 with and without the base-address qualifier.
    step(16'h0001, 16'h0000, 1'b1, 32'h12345678);
    step(16'h0000, 16'h0001, 1'b0, 32'h0);
    chk("r0_ba0", q_out, 32'h12345678);
    step(16'h0000, 16'h0001, 1'b1, 32'h0);
    chk("r0_ba1", q_out, 32'h0);
    step(16'h0000, 16'h0020, 1'b1, 32'h0);
    chk("r5_ba1", q_out, 32'hDEADBEEF);

    // Same-cycle write and read of R10: old value before, new after.
    step(16'h0400, 16'h0000, 1'b0, 32'h00000001);
    Rin = 16'h0400; Rout = 16'h0400; BAout = 1'b0; d_in = 32'hA5A5A5A5;
    #1;
    chk("r10_old", q_out, 32'h00000001);
    step(16'h0400, 16'h0400, 1'b0, 32'hA5A5A5A5);
    chk("r10_new", q_out, 32'hA5A5A5A5);

    // Legal random traffic.
    for (int i = 0; i < 400; i++)
      step(gen_sel(0), gen_sel(0), 1'($urandom_range(0, 1)), $urandom);

    // Multi-hot write: R0/R1 hold, count holds, flag sets and sticks.
    step(16'h0001, 16'h0000, 1'b0, 32'h0000AAAA);
    step(16'h0002, 16'h0000, 1'b0, 32'h0000BBBB);
    step(16'h0003, 16'h0000, 1'b0, 32'hFFFFFFFF);
    chk("mh_sel_err", {31'h0, sel_err}, 32'h1);
    step(16'h0000, 16'h0001, 1'b0, 32'h0);
    chk("mh_r0", q_out, 32'h0000AAAA);
    step(16'h0000, 16'h0002, 1'b0, 32'h0);
    chk("mh_r1", q_out, 32'h0000BBBB);
    for (int i = 0; i < 10; i++) begin
      step(gen_sel(0), gen_sel(0), 1'b0, $urandom);
      chk("mh_sticky", {31'h0, sel_err}, 32'h1);
    end

    // Random traffic including multi-hot selects.
    for (int i = 0; i < 100; i++)
      step(gen_sel(10), gen_sel(10), 1'($urandom_range(0, 1)), $urandom);

    pulse_clr();
    step(16'h0004, 16'h0004, 1'b0, 32'h11112222);
    chk("post_clr_write", q_out, 32'h11112222);

    // Multi-hot read select.
    Rin = 16'h0; Rout = 16'h8001; BAout = 1'b0;
    #1;
    chk("rmh_q", q_out, 32'h0);
    chk("rmh_rd_act", {31'h0, rd_act}, 32'h0);
    chk("rmh_pre_err", {31'h0, sel_err}, 32'h0);
    step(16'h0000, 16'h8001, 1'b0, 32'h0);
    chk("rmh_sel_err", {31'h0, sel_err}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
